// File: rtl/ram_sync.sv
// Single-port synchronous RAM with write-first read data and registered output.
// Reset asynchronously clears both the output register and every stored word.
module ram_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] address,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned WORDS = 2 ** DEPTH;

    logic [WIDTH-1:0] mem [WORDS];

    // Storage array: cleared as a whole on reset so post-reset reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (enable && wr_en) begin
            mem[address] <= data_in;
        end
    end

    // Output register: a write forwards the new data, a read loads the stored word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (enable) begin
            if (wr_en) begin
                data_out <= data_in;
            end else begin
                data_out <= mem[address];
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Directed self-checking bench for ram_sync: reset clearing, write-first,
// hold on enable low, back-to-back access and mid-operation reset.
module tb_ram_sync;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [3:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    ram_sync #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .wr_en    (wr_en),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Apply one access just after an edge, then return 1 time unit past the next edge
    task automatic access(input logic en, input logic we, input logic [3:0] a, input logic [7:0] d);
        enable  = en;
        wr_en   = we;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        enable  = 1'b0;
        wr_en   = 1'b0;
        address = 4'd0;
        data_in = 8'h00;
        #1 rst_n = 1'b0;
        #1 check("reset_out", data_out, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh memory reads zero at every probed address
        for (int i = 0; i < 5; i++) begin
            access(1'b1, 1'b0, 4'(i), 8'hEE);
            check($sformatf("read_zero_%0d", i), data_out, 8'h00);
        end

        // Write-first then read-back, neighbour untouched
        access(1'b1, 1'b1, 4'd5, 8'hFF);
        check("wr5_first", data_out, 8'hFF);
        access(1'b1, 1'b0, 4'd5, 8'h00);
        check("rd5", data_out, 8'hFF);
        access(1'b1, 1'b0, 4'd4, 8'h00);
        check("rd4", data_out, 8'h00);

        // Enable low holds output and contents
        access(1'b1, 1'b0, 4'd5, 8'h00);
        check("rd5_again", data_out, 8'hFF);
        access(1'b0, 1'b1, 4'd5, 8'h12);
        check("hold_0", data_out, 8'hFF);
        access(1'b0, 1'b0, 4'd3, 8'h12);
        check("hold_1", data_out, 8'hFF);
        access(1'b0, 1'b1, 4'd9, 8'h12);
        check("hold_2", data_out, 8'hFF);
        access(1'b1, 1'b0, 4'd5, 8'h00);
        check("rd5_after_hold", data_out, 8'hFF);

        // Extreme addresses back-to-back
        access(1'b1, 1'b1, 4'd15, 8'hA5);
        check("wr15", data_out, 8'hA5);
        access(1'b1, 1'b1, 4'd0, 8'h3C);
        check("wr0", data_out, 8'h3C);
        access(1'b1, 1'b0, 4'd15, 8'h00);
        check("rd15", data_out, 8'hA5);
        access(1'b1, 1'b0, 4'd0, 8'h00);
        check("rd0", data_out, 8'h3C);

        // Same address written twice, last write wins
        access(1'b1, 1'b1, 4'd2, 8'h11);
        check("wr2_a", data_out, 8'h11);
        access(1'b1, 1'b1, 4'd2, 8'h22);
        check("wr2_b", data_out, 8'h22);
        access(1'b1, 1'b0, 4'd2, 8'h00);
        check("rd2", data_out, 8'h22);

        // Inputs changed between edges only count at the edge
        enable  = 1'b1;
        wr_en   = 1'b1;
        address = 4'd6;
        data_in = 8'h99;
        #3 data_in = 8'h66;
        access(1'b1, 1'b1, 4'd6, 8'h66);
        check("wr6_late_change", data_out, 8'h66);
        access(1'b1, 1'b0, 4'd6, 8'h00);
        check("rd6", data_out, 8'h66);

        // Mid-operation asynchronous reset
        access(1'b1, 1'b1, 4'd7, 8'h55);
        check("wr7", data_out, 8'h55);
        #2 rst_n = 1'b0;
        #1 check("async_clear", data_out, 8'h00);
        enable  = 1'b1;
        wr_en   = 1'b1;
        address = 4'd7;
        data_in = 8'hC3;
        @(posedge clk);
        #1 check("ignored_in_reset", data_out, 8'h00);
        #2 rst_n = 1'b1;
        access(1'b1, 1'b0, 4'd7, 8'h00);
        check("rd7_after_reset", data_out, 8'h00);
        access(1'b1, 1'b0, 4'd5, 8'h00);
        check("rd5_after_reset", data_out, 8'h00);
        access(1'b1, 1'b0, 4'd15, 8'h00);
        check("rd15_after_reset", data_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
